mxv_result_collector: RTL and testbench

//  Read-side counterpart of the round-robin push sequencer feeding the four MxV lane FIFOs.

---
 rtl/mxv_collect_if.sv | 47 ++++
 rtl/mxv_result_collector.sv | 161 ++++++++++++++++
 tb/tb_mxv_result_collector.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mxv_collect_if.sv
// Bus bundle between the MxV result collector, its four lane FIFOs and the downstream consumer.
// The master modport is the collector side; the slave modport is the FIFO/consumer side.
interface mxv_collect_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  start;
   logic [7:0]            matrixSize;
   logic                  empty1;
   logic                  empty2;
   logic                  empty3;
   logic                  empty4;
   logic [DATA_WIDTH-1:0] data1;
   logic [DATA_WIDTH-1:0] data2;
   logic [DATA_WIDTH-1:0] data3;
   logic [DATA_WIDTH-1:0] data4;
   logic                  pop1;
   logic                  pop2;
   logic                  pop3;
   logic                  pop4;
   logic [DATA_WIDTH-1:0] out_data;
   logic [7:0]            out_index;
   logic                  out_valid;
   logic                  out_ready;
   logic                  busy;
   logic                  done;
   logic                  error;

   modport master (
      input  start, matrixSize,
      input  empty1, empty2, empty3, empty4,
      input  data1, data2, data3, data4,
      input  out_ready,
      output pop1, pop2, pop3, pop4,
      output out_data, out_index, out_valid,
      output busy, done, error
   );

   modport slave (
      output start, matrixSize,
      output empty1, empty2, empty3, empty4,
      output data1, data2, data3, data4,
      output out_ready,
      input  pop1, pop2, pop3, pop4,
      input  out_data, out_index, out_valid,
      input  busy, done, error
   );
endinterface

// File: rtl/mxv_result_collector.sv
// Drains the four MxV lane FIFOs in order 4,3,2,1,... and serialises the elements onto a valid/ready stream.
// Optional stall timeout with sticky error is built when MXV_COLLECT_TIMEOUT_EN is defined.
module mxv_result_collector #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned MAX_SIZE       = 8,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic          clk,
   input  logic          reset,
   mxv_collect_if.master bus
);

   if (MAX_SIZE == 0 || MAX_SIZE > 255 || TIMEOUT_CYCLES == 0) begin : g_param_check
      $error("mxv_result_collector: MAX_SIZE must be 1..255 and TIMEOUT_CYCLES must be nonzero");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_CAPTURE,
      S_PRESENT,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [7:0]            r_size;
   logic [7:0]            r_idx;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [7:0]            r_out_index;
   logic                  r_out_valid;
   logic                  r_busy;
   logic                  r_done;
   logic [3:0]            w_pop;
   logic                  w_lane_empty;
   logic [DATA_WIDTH-1:0] w_lane_data;
   logic [7:0]            w_size_clamped;
   logic                  w_timeout;
   logic                  w_accept;
   logic                  w_last;

   assign w_size_clamped = (bus.matrixSize > 8'(MAX_SIZE)) ? 8'(MAX_SIZE) : bus.matrixSize;
   assign w_accept       = r_out_valid && bus.out_ready;
   assign w_last         = (r_idx == r_size - 8'd1);

   // Lane select: idx mod 4 of 0,1,2,3 maps to lanes 4,3,2,1
   always_comb begin
      w_lane_empty = bus.empty4;
      w_lane_data  = bus.data4;
      case (r_idx[1:0])
         2'd0: begin w_lane_empty = bus.empty4; w_lane_data = bus.data4; end
         2'd1: begin w_lane_empty = bus.empty3; w_lane_data = bus.data3; end
         2'd2: begin w_lane_empty = bus.empty2; w_lane_data = bus.data2; end
         default: begin w_lane_empty = bus.empty1; w_lane_data = bus.data1; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state and the pop strobe, which must fire in the same cycle the empty flag is seen low
   always_comb begin
      w_next = r_state;
      w_pop  = 4'b0000;
      case (r_state)
         S_IDLE: begin
            if (bus.start) w_next = (w_size_clamped == 8'd0) ? S_DONE : S_POP;
         end
         S_POP: begin
            if (!w_lane_empty) begin
               w_pop  = 4'(4'b1000 >> r_idx[1:0]);
               w_next = S_CAPTURE;
            end else if (w_timeout) begin
               w_next = S_DONE;
            end
         end
         S_CAPTURE: w_next = S_PRESENT;
         S_PRESENT: begin
            if (w_accept) w_next = w_last ? S_DONE : S_POP;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_size      <= 8'd0;
         r_idx       <= 8'd0;
         r_out_data  <= '0;
         r_out_index <= 8'd0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_size <= w_size_clamped;
                  r_idx  <= 8'd0;
                  r_busy <= 1'b1;
               end
            end
            S_CAPTURE: begin
               r_out_data  <= w_lane_data;
               r_out_index <= r_idx;
               r_out_valid <= 1'b1;
            end
            S_PRESENT: begin
               if (w_accept) begin
                  r_out_valid <= 1'b0;
                  if (!w_last) r_idx <= r_idx + 8'd1;
               end
            end
            S_DONE:  r_busy <= 1'b0;
            default: ;
         endcase
      end
   end

`ifdef MXV_COLLECT_TIMEOUT_EN
   localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [STALL_W-1:0] r_stall;
   logic               r_error;

   // Fires on the TIMEOUT_CYCLES-th consecutive stalled POP cycle
   assign w_timeout = (r_state == S_POP) && w_lane_empty &&
                      (r_stall == STALL_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_stall <= '0;
         r_error <= 1'b0;
      end else begin
         if ((r_state == S_POP) && w_lane_empty) r_stall <= r_stall + 1'b1;
         else                                    r_stall <= '0;
         if (w_timeout) r_error <= 1'b1;
      end
   end

   assign bus.error = r_error;
`else
   assign w_timeout = 1'b0;
   assign bus.error = 1'b0;
`endif

   assign bus.pop1      = w_pop[0];
   assign bus.pop2      = w_pop[1];
   assign bus.pop3      = w_pop[2];
   assign bus.pop4      = w_pop[3];
   assign bus.out_data  = r_out_data;
   assign bus.out_index = r_out_index;
   assign bus.out_valid = r_out_valid;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

endmodule

// File: tb/tb_mxv_result_collector.sv
// Directed bench for mxv_result_collector: models four lane FIFOs and logs pops, accepts and done pulses.
module tb_mxv_result_collector;
   localparam int unsigned DW = 16;

   logic clk = 1'b0;
   logic reset;

   mxv_collect_if #(.DATA_WIDTH(DW)) bus ();

   mxv_result_collector #(
      .DATA_WIDTH(DW),
      .MAX_SIZE(8),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem [4][32];
   int            wr [4] = '{default: 0};
   int            rd [4] = '{default: 0};
   bit            force_e [4] = '{default: 1'b0};
   logic [DW-1:0] dq [4] = '{default: '0};

   int            cyc = 0;
   int            pop_n = 0;
   int            pop_lane [256];
   int            pop_cyc [256];
   int            acc_n = 0;
   logic [DW-1:0] acc_data [256];
   int            acc_idx [256];
   int            acc_cyc [256];
   int            done_n = 0;
   int            done_cyc = 0;
   logic [3:0]    w_pv;
   logic [7:0]    w_ctrl;

   assign bus.empty1 = (wr[0] == rd[0]) || force_e[0];
   assign bus.empty2 = (wr[1] == rd[1]) || force_e[1];
   assign bus.empty3 = (wr[2] == rd[2]) || force_e[2];
   assign bus.empty4 = (wr[3] == rd[3]) || force_e[3];
   assign bus.data1  = dq[0];
   assign bus.data2  = dq[1];
   assign bus.data3  = dq[2];
   assign bus.data4  = dq[3];
   assign w_pv   = {bus.pop4, bus.pop3, bus.pop2, bus.pop1};
   assign w_ctrl = {w_pv, bus.out_valid, bus.busy, bus.done, bus.error};

   // FIFO read model plus event logs; all indices record the pre-edge cycle count
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int l = 0; l < 4; l++) begin
         if (w_pv[l]) begin
            dq[l]           <= mem[l][5'(rd[l])];
            rd[l]           <= rd[l] + 1;
            pop_lane[pop_n] <= l + 1;
            pop_cyc[pop_n]  <= cyc;
            pop_n           <= pop_n + 1;
         end
      end
      if (bus.out_valid && bus.out_ready) begin
         acc_data[acc_n] <= bus.out_data;
         acc_idx[acc_n]  <= int'(bus.out_index);
         acc_cyc[acc_n]  <= cyc;
         acc_n           <= acc_n + 1;
      end
      if (bus.done) begin
         done_n   <= done_n + 1;
         done_cyc <= cyc;
      end
   end

   task automatic push(input int lane, input logic [DW-1:0] v);
      mem[lane-1][5'(wr[lane-1])] = v;
      wr[lane-1] = wr[lane-1] + 1;
   endtask

   // Element i of a collection lives in lane 4-(i mod 4)
   task automatic fill(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) push(4 - (i % 4), base + DW'(i));
   endtask

   task automatic flush();
      for (int l = 0; l < 4; l++) wr[l] = rd[l];
   endtask

   task automatic start_op(input int n, output int t0);
      @(negedge clk);
      bus.matrixSize = 8'(n);
      bus.start      = 1'b1;
      @(posedge clk);
      t0 = cyc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_n != d0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (w_ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %0h exp 0", w_ctrl); end
      checks++;
      if (bus.out_data !== '0) begin errors++; $display("FAIL reset_data got %0h exp 0", bus.out_data); end
      checks++;
      if (bus.out_index !== 8'd0) begin errors++; $display("FAIL reset_index got %0d exp 0", bus.out_index); end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (w_ctrl !== 8'h00) begin errors++; $display("FAIL idle_ctrl got %0h exp 0", w_ctrl); end
   endtask

   task automatic test_full();
      int p0, a0, d0, t0;
      bit ok;
      flush();
      fill(8, 16'hA000);
      p0 = pop_n; a0 = acc_n; d0 = done_n;
      bus.out_ready = 1'b1;
      start_op(8, t0);
      wait_done(d0, 200, ok);
      repeat (3) @(negedge clk);
      checks++;
      if (!ok) begin errors++; $display("FAIL full_done_timeout got 0 exp 1"); end
      checks++;
      if (pop_n - p0 != 8) begin errors++; $display("FAIL full_pop_count got %0d exp 8", pop_n - p0); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (pop_lane[p0+i] != 4 - (i % 4)) begin
            errors++; $display("FAIL full_pop_lane[%0d] got %0d exp %0d", i, pop_lane[p0+i], 4 - (i % 4));
         end
      end
      checks++;
      if (acc_n - a0 != 8) begin errors++; $display("FAIL full_acc_count got %0d exp 8", acc_n - a0); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (acc_idx[a0+i] != i || acc_data[a0+i] !== 16'hA000 + DW'(i)) begin
            errors++;
            $display("FAIL full_elem[%0d] got idx %0d data %0h exp idx %0d data %0h",
                     i, acc_idx[a0+i], acc_data[a0+i], i, 16'hA000 + DW'(i));
         end
      end
      checks++;
      if (acc_cyc[a0] - t0 != 3) begin errors++; $display("FAIL full_first_latency got %0d exp 3", acc_cyc[a0] - t0); end
      checks++;
      if (acc_cyc[a0+7] - t0 != 24) begin errors++; $display("FAIL full_last_accept got %0d exp 24", acc_cyc[a0+7] - t0); end
      checks++;
      if (done_n - d0 != 1) begin errors++; $display("FAIL full_done_pulses got %0d exp 1", done_n - d0); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got %0b exp 0", bus.busy); end
   endtask

   task automatic test_size0();
      int p0, a0, d0, t0;
      bit ok;
      p0 = pop_n; a0 = acc_n; d0 = done_n;
      start_op(0, t0);
      wait_done(d0, 20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL size0_done_timeout got 0 exp 1"); end
      checks++;
      if (done_cyc - t0 != 2) begin errors++; $display("FAIL size0_done_latency got %0d exp 2", done_cyc - t0); end
      checks++;
      if (pop_n != p0 || acc_n != a0) begin
         errors++; $display("FAIL size0_activity got pops %0d accepts %0d exp 0 0", pop_n - p0, acc_n - a0);
      end
   endtask

   task automatic test_clamp();
      int p0, a0, d0, t0;
      bit ok;
      flush();
      fill(12, 16'hB000);
      p0 = pop_n; a0 = acc_n; d0 = done_n;
      start_op(20, t0);
      wait_done(d0, 200, ok);
      repeat (4) @(negedge clk);
      checks++;
      if (!ok) begin errors++; $display("FAIL clamp_done_timeout got 0 exp 1"); end
      checks++;
      if (acc_n - a0 != 8 || pop_n - p0 != 8) begin
         errors++; $display("FAIL clamp_count got acc %0d pops %0d exp 8 8", acc_n - a0, pop_n - p0);
      end
      checks++;
      if (acc_idx[a0+7] != 7 || acc_data[a0+7] !== 16'hB007) begin
         errors++; $display("FAIL clamp_last got idx %0d data %0h exp 7 b007", acc_idx[a0+7], acc_data[a0+7]);
      end
      checks++;
      if (done_n - d0 != 1) begin errors++; $display("FAIL clamp_done_pulses got %0d exp 1", done_n - d0); end
      flush();
   endtask

   task automatic test_backpressure();
      int a0, d0, t0, pn;
      bit ok, found;
      flush();
      fill(4, 16'hD000);
      a0 = acc_n; d0 = done_n;
      bus.out_ready = 1'b1;
      start_op(4, t0);
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.out_valid && bus.out_index == 8'd2) begin found = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!found) begin errors++; $display("FAIL bp_elem2_timeout got 0 exp 1"); end
      bus.out_ready = 1'b0;
      pn = pop_n;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_index !== 8'd2 || bus.out_data !== 16'hD002) begin
            errors++;
            $display("FAIL bp_hold[%0d] got v %0b idx %0d data %0h exp 1 2 d002",
                     k, bus.out_valid, bus.out_index, bus.out_data);
         end
         @(negedge clk);
      end
      checks++;
      if (pop_n != pn) begin errors++; $display("FAIL bp_no_pop got %0d exp 0", pop_n - pn); end
      bus.out_ready = 1'b1;
      wait_done(d0, 100, ok);
      checks++;
      if (!ok || acc_n - a0 != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", acc_n - a0); end
      checks++;
      if (acc_idx[a0+2] != 2 || acc_data[a0+2] !== 16'hD002 || acc_data[a0+3] !== 16'hD003) begin
         errors++; $display("FAIL bp_data got %0h %0h exp d002 d003", acc_data[a0+2], acc_data[a0+3]);
      end
      checks++;
      if (acc_cyc[a0+2] - acc_cyc[a0+1] != 8) begin
         errors++; $display("FAIL bp_gap got %0d exp 8", acc_cyc[a0+2] - acc_cyc[a0+1]);
      end
   endtask

   task automatic test_stall();
      int a0, d0, t0, pn, e;
      bit ok, found;
      flush();
      fill(4, 16'hE000);
      force_e[2] = 1'b1;
      a0 = acc_n; d0 = done_n;
      bus.out_ready = 1'b1;
      start_op(4, t0);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (acc_n - a0 == 1) begin found = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!found) begin errors++; $display("FAIL stall_first_timeout got 0 exp 1"); end
      pn = pop_n;
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (w_pv !== 4'b0000) begin errors++; $display("FAIL stall_pops[%0d] got %0b exp 0000", k, w_pv); end
         @(negedge clk);
      end
      checks++;
      if (pop_n != pn) begin errors++; $display("FAIL stall_pop_count got %0d exp 0", pop_n - pn); end
      force_e[2] = 1'b0;
      @(posedge clk);
      e = cyc;
      wait_done(d0, 100, ok);
      checks++;
      if (pop_lane[pn] != 3 || pop_cyc[pn] != e) begin
         errors++; $display("FAIL stall_resume got lane %0d at %0d exp lane 3 at %0d", pop_lane[pn], pop_cyc[pn], e);
      end
      checks++;
      if (!ok || acc_n - a0 != 4 || acc_data[a0+1] !== 16'hE001) begin
         errors++; $display("FAIL stall_result got %0d elems data1 %0h exp 4 e001", acc_n - a0, acc_data[a0+1]);
      end
   endtask

`ifdef MXV_COLLECT_TIMEOUT_EN
   task automatic test_timeout();
      int p0, a0, d0, t0;
      bit ok;
      flush();
      fill(4, 16'hF000);
      force_e[2] = 1'b1;
      p0 = pop_n; a0 = acc_n; d0 = done_n;
      start_op(4, t0);
      wait_done(d0, 100, ok);
      checks++;
      if (!ok || done_cyc - t0 != 21) begin
         errors++; $display("FAIL timeout_done got ok %0b at %0d exp 1 at 21", ok, done_cyc - t0);
      end
      checks++;
      if (bus.error !== 1'b1) begin errors++; $display("FAIL timeout_error got %0b exp 1", bus.error); end
      checks++;
      if (pop_n - p0 != 1 || acc_n - a0 != 1) begin
         errors++; $display("FAIL timeout_count got pops %0d acc %0d exp 1 1", pop_n - p0, acc_n - a0);
      end
      force_e[2] = 1'b0;
      flush();
   endtask
`endif

   task automatic test_reset_mid();
      int p0, a0, d0, t0;
      bit ok, found;
      flush();
      fill(4, 16'h1230);
      bus.out_ready = 1'b0;
      start_op(4, t0);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.out_valid) begin found = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!found || cyc - t0 < 3) begin errors++; $display("FAIL rmid_present_timeout got %0b exp 1", found); end
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      checks++;
      if (w_ctrl !== 8'h00 || bus.out_data !== '0 || bus.out_index !== 8'd0) begin
         errors++; $display("FAIL rmid_outputs got ctrl %0h data %0h idx %0d exp 0 0 0",
                            w_ctrl, bus.out_data, bus.out_index);
      end
      flush();
      fill(4, 16'hC000);
      p0 = pop_n; a0 = acc_n; d0 = done_n;
      bus.out_ready = 1'b1;
      start_op(4, t0);
      wait_done(d0, 100, ok);
      checks++;
      if (!ok || acc_n - a0 != 4 || pop_n - p0 != 4) begin
         errors++; $display("FAIL rmid_count got acc %0d pops %0d exp 4 4", acc_n - a0, pop_n - p0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (acc_idx[a0+i] != i || acc_data[a0+i] !== 16'hC000 + DW'(i) || pop_lane[p0+i] != 4 - i) begin
            errors++;
            $display("FAIL rmid_elem[%0d] got idx %0d data %0h lane %0d exp %0d %0h %0d",
                     i, acc_idx[a0+i], acc_data[a0+i], pop_lane[p0+i], i, 16'hC000 + DW'(i), 4 - i);
         end
      end
   endtask

   initial begin
      reset          = 1'b0;
      bus.start      = 1'b0;
      bus.matrixSize = 8'd0;
      bus.out_ready  = 1'b0;
      test_reset();
      test_full();
      test_size0();
      test_clamp();
      test_backpressure();
      test_stall();
`ifdef MXV_COLLECT_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
